// File: rtl/mcu_spi_select.sv
// mcu_spi_select: chooses the on-board BL616 or an external M0S Dock as master of the core SPI link
//   clk32, por                      : 32 MHz clock, asynchronous active-high reset
//   int_sclk/int_csn/int_mosi       : on-board MCU SPI pins
//   ext_sclk/ext_csn/ext_mosi       : external MCU SPI pins (ext_csn pulled up)
//   core_miso, core_intn            : core MISO and interrupt, fanned out unregistered to both MCUs
//   int_miso/ext_miso, int_irqn/ext_irqn : combinational copies for each MCU
//   mcu_sclk/mcu_csn/mcu_mosi       : selected, synchronised and registered SPI towards the core
//   ext_active                      : high while the external MCU owns the link
module mcu_spi_select #(
    parameter int FILTER        = 4,
    parameter int REVERT_CYCLES = 0
) (
    input  logic clk32,
    input  logic por,
    input  logic int_sclk,
    input  logic int_csn,
    input  logic int_mosi,
    input  logic ext_sclk,
    input  logic ext_csn,
    input  logic ext_mosi,
    input  logic core_miso,
    input  logic core_intn,
    output logic int_miso,
    output logic ext_miso,
    output logic int_irqn,
    output logic ext_irqn,
    output logic mcu_sclk,
    output logic mcu_csn,
    output logic mcu_mosi,
    output logic ext_active
);
    typedef enum logic [1:0] {ST_INT, ST_WAIT_EXT, ST_EXT, ST_WAIT_INT} state_t;
    localparam logic [5:0] SYNC_RST = 6'b010_010;
    localparam logic [2:0] IDLE     = 3'b010;
    state_t      state_q, state_d;
    logic [5:0]  meta_q, sync_q;
    logic [3:0]  filt_q, filt_d;
    logic [23:0] idle_q, idle_d;
    logic [2:0]  out_q, out_d;
    logic        s_int_sclk, s_int_csn, s_int_mosi, s_ext_sclk, s_ext_csn, s_ext_mosi;
    logic        qual, both_idle;
    assign {s_int_sclk, s_int_csn, s_int_mosi, s_ext_sclk, s_ext_csn, s_ext_mosi} = sync_q;
    assign int_miso   = core_miso;
    assign ext_miso   = core_miso;
    assign int_irqn   = core_intn;
    assign ext_irqn   = core_intn;
    assign {mcu_sclk, mcu_csn, mcu_mosi} = out_q;
    assign ext_active = state_q == ST_EXT;
    assign qual       = state_q == ST_INT && filt_q == 4'(FILTER);
    assign both_idle  = s_int_csn && s_ext_csn;
    always_comb begin
        state_d = state_q;
        out_d   = IDLE;
        // Both counters sit at zero outside their own state, so each starts fresh on entry.
        filt_d  = state_q != ST_INT ? 4'd0 : s_ext_csn ? 4'd0 : qual ? filt_q : filt_q + 4'd1;
        idle_d  = state_q != ST_EXT ? 24'd0 : !s_ext_csn ? 24'd0 : &idle_q ? idle_q : idle_q + 24'd1;
        case (state_q)
            ST_INT: begin
                out_d = {s_int_sclk, s_int_csn, s_int_mosi};
                if (qual) state_d = ST_WAIT_EXT;
            end
            ST_WAIT_EXT: if (both_idle) state_d = ST_EXT;
            ST_EXT: begin
                out_d = {s_ext_sclk, s_ext_csn, s_ext_mosi};
                // Compare the next count so a csn fall on the limit cycle (count cleared) cancels the revert.
                if (REVERT_CYCLES != 0 && idle_d == 24'(REVERT_CYCLES)) state_d = ST_WAIT_INT;
            end
            ST_WAIT_INT: if (both_idle) state_d = ST_INT;
            default: state_d = ST_INT;
        endcase
    end
    always_ff @(posedge clk32 or posedge por) begin
        if (por) begin
            meta_q  <= SYNC_RST;
            sync_q  <= SYNC_RST;
            state_q <= ST_INT;
            filt_q  <= '0;
            idle_q  <= '0;
            out_q   <= IDLE;
        end else begin
            meta_q  <= {int_sclk, int_csn, int_mosi, ext_sclk, ext_csn, ext_mosi};
            sync_q  <= meta_q;
            state_q <= state_d;
            filt_q  <= filt_d;
            idle_q  <= idle_d;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_mcu_spi_select.sv
// tb_mcu_spi_select: scenario and randomized checks of the SPI source selector against frame-level expectations
module tb_mcu_spi_select;
    localparam int FILTER = 4;
    localparam int REVERT = 100;
    logic clk32 = 1'b0, por = 1'b1;
    logic int_sclk = 1'b0, int_csn = 1'b1, int_mosi = 1'b0;
    logic ext_sclk = 1'b0, ext_csn = 1'b1, ext_mosi = 1'b0;
    logic core_miso = 1'b0, core_intn = 1'b1;
    logic int_miso, ext_miso, int_irqn, ext_irqn, mcu_sclk, mcu_csn, mcu_mosi, ext_active;
    logic int_miso0, ext_miso0, int_irqn0, ext_irqn0, mcu_sclk0, mcu_csn0, mcu_mosi0, ext_active0;
    int checks = 0, fails = 0;
    logic [2:0] wave[$];
    logic [7:0] rx[$];
    logic [7:0] sh = 8'h00;
    int nb = 0;
    logic prev_sclk = 1'b0, prev_csn = 1'b1;

    mcu_spi_select #(.FILTER(FILTER), .REVERT_CYCLES(REVERT)) dut (
        .clk32(clk32), .por(por),
        .int_sclk(int_sclk), .int_csn(int_csn), .int_mosi(int_mosi),
        .ext_sclk(ext_sclk), .ext_csn(ext_csn), .ext_mosi(ext_mosi),
        .core_miso(core_miso), .core_intn(core_intn),
        .int_miso(int_miso), .ext_miso(ext_miso), .int_irqn(int_irqn), .ext_irqn(ext_irqn),
        .mcu_sclk(mcu_sclk), .mcu_csn(mcu_csn), .mcu_mosi(mcu_mosi), .ext_active(ext_active)
    );

    // Same stimulus, latch-forever configuration.
    mcu_spi_select #(.FILTER(FILTER), .REVERT_CYCLES(0)) dut0 (
        .clk32(clk32), .por(por),
        .int_sclk(int_sclk), .int_csn(int_csn), .int_mosi(int_mosi),
        .ext_sclk(ext_sclk), .ext_csn(ext_csn), .ext_mosi(ext_mosi),
        .core_miso(core_miso), .core_intn(core_intn),
        .int_miso(int_miso0), .ext_miso(ext_miso0), .int_irqn(int_irqn0), .ext_irqn(ext_irqn0),
        .mcu_sclk(mcu_sclk0), .mcu_csn(mcu_csn0), .mcu_mosi(mcu_mosi0), .ext_active(ext_active0)
    );

    always #15 clk32 = ~clk32;

    // Frame decoder on the core side: collects complete 8-bit mode-0 frames.
    always @(negedge clk32) begin
        if (!mcu_csn && mcu_sclk && !prev_sclk) begin
            sh <= {sh[6:0], mcu_mosi};
            nb <= nb + 1;
        end
        if (!mcu_csn && prev_csn) nb <= 0;
        if (mcu_csn && !prev_csn && nb == 8) rx.push_back(sh);
        prev_sclk <= mcu_sclk;
        prev_csn  <= mcu_csn;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Waveform of one frame at 2 MHz (16 clk32 cycles per bit), entries are {sclk, csn, mosi}.
    task automatic make_wave(input logic [7:0] b);
        wave.delete();
        repeat (4) wave.push_back(3'b010);
        repeat (4) wave.push_back({2'b00, b[7]});
        for (int k = 7; k >= 0; k--) begin
            repeat (8) wave.push_back({2'b00, b[k]});
            repeat (8) wave.push_back({2'b10, b[k]});
        end
        repeat (4) wave.push_back(3'b000);
        repeat (6) wave.push_back(3'b010);
    endtask

    task automatic set_pins(input bit ext, input logic [2:0] v);
        if (ext) {ext_sclk, ext_csn, ext_mosi} = v;
        else {int_sclk, int_csn, int_mosi} = v;
    endtask

    task automatic drive_wave(input bit ext);
        for (int i = 0; i < wave.size(); i++) begin
            set_pins(ext, wave[i]);
            tick();
        end
    endtask

    task automatic test_reset();
        int_csn = 1'b0;
        int_sclk = 1'b1;
        ticks(3);
        checks++;
        if ({mcu_sclk, mcu_csn, mcu_mosi, ext_active} !== 4'b0100) begin
            fails++;
            $display("FAIL reset_outputs got %b want 0100", {mcu_sclk, mcu_csn, mcu_mosi, ext_active});
        end
        for (int i = 0; i < 4; i++) begin
            core_miso = 1'($urandom);
            core_intn = 1'($urandom);
            #1;
            checks++;
            if ({int_miso, ext_miso, int_irqn, ext_irqn} !== {core_miso, core_miso, core_intn, core_intn}) begin
                fails++;
                $display("FAIL passthrough got %b want %b", {int_miso, ext_miso, int_irqn, ext_irqn},
                         {core_miso, core_miso, core_intn, core_intn});
            end
        end
        int_csn = 1'b1;
        int_sclk = 1'b0;
        tick();
        por = 1'b0;
        ticks(4);
    endtask

    task automatic test_idle_frame();
        make_wave(8'hA5);
        rx.delete();
        for (int i = 0; i < wave.size(); i++) begin
            set_pins(0, wave[i]);
            tick();
            // A pin value first sampled on edge k shows on mcu_* after edge k+2 (3 edges).
            if (i >= 2) begin
                checks++;
                if ({mcu_sclk, mcu_csn, mcu_mosi} !== wave[i-2]) begin
                    fails++;
                    $display("FAIL idle_delay idx %0d got %b want %b", i, {mcu_sclk, mcu_csn, mcu_mosi}, wave[i-2]);
                end
            end
        end
        ticks(4);
        checks++;
        if (rx.size() != 1 || rx[0] !== 8'hA5 || ext_active !== 1'b0) begin
            fails++;
            $display("FAIL idle_frame got %0d frames, first %h, ext_active %b want 1 frame a5, ext_active 0",
                     rx.size(), rx.size() ? rx[0] : 8'h00, ext_active);
        end
    endtask

    task automatic test_glitch();
        int hi = 0;
        rx.delete();
        ext_csn = 1'b0;
        ticks(FILTER - 1);
        ext_csn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            hi |= int'(ext_active);
        end
        checks++;
        if (hi != 0) begin
            fails++;
            $display("FAIL glitch_state ext_active seen %0d want 0", hi);
        end
        make_wave(8'hC3);
        drive_wave(0);
        ticks(4);
        checks++;
        if (rx.size() != 1 || rx[0] !== 8'hC3) begin
            fails++;
            $display("FAIL glitch_frame got %0d frames, first %h want 1 frame c3", rx.size(), rx.size() ? rx[0] : 8'h00);
        end
    endtask

    task automatic test_handover();
        rx.delete();
        make_wave(8'h81);
        for (int i = 0; i < wave.size(); i++) begin
            set_pins(1, wave[i]);
            tick();
            if (i == 60) begin
                checks++;
                if ({ext_active, mcu_csn} !== 2'b01) begin
                    fails++;
                    $display("FAIL handover_wait got ext_active %b csn %b want 0 1", ext_active, mcu_csn);
                end
            end
        end
        for (int n = 0; n < 12 && !ext_active; n++) tick();
        checks++;
        if (ext_active !== 1'b1 || ext_active0 !== 1'b1) begin
            fails++;
            $display("FAIL handover_active got %b/%b want 1/1", ext_active, ext_active0);
        end
        checks++;
        if (rx.size() != 0) begin
            fails++;
            $display("FAIL handover_first_frame got %0d frames want 0", rx.size());
        end
        make_wave(8'h3C);
        drive_wave(1);
        ticks(4);
        checks++;
        if (rx.size() != 1 || rx[0] !== 8'h3C) begin
            fails++;
            $display("FAIL handover_frame got %0d frames, first %h want 1 frame 3c", rx.size(), rx.size() ? rx[0] : 8'h00);
        end
    endtask

    task automatic test_revert_boundary();
        ext_csn = 1'b0;
        ticks(3);
        ext_csn = 1'b1;
        ticks(99);
        // The 100th synchronised sample is low: the count clears instead of reaching the limit.
        ext_csn = 1'b0;
        ticks(9);
        checks++;
        if (ext_active !== 1'b1) begin
            fails++;
            $display("FAIL revert_99 got ext_active %b want 1", ext_active);
        end
    endtask

    task automatic test_revert();
        ext_csn = 1'b1;
        ticks(101);
        checks++;
        if (ext_active !== 1'b1) begin
            fails++;
            $display("FAIL revert_early got ext_active %b want 1 after 99 idle samples", ext_active);
        end
        tick();
        checks++;
        if (ext_active !== 1'b0) begin
            fails++;
            $display("FAIL revert_100 got ext_active %b want 0 after 100 idle samples", ext_active);
        end
        ticks(100);
        checks++;
        if (ext_active0 !== 1'b1) begin
            fails++;
            $display("FAIL latch_forever got ext_active %b want 1", ext_active0);
        end
        rx.delete();
        make_wave(8'h5A);
        drive_wave(0);
        ticks(4);
        checks++;
        if (rx.size() != 1 || rx[0] !== 8'h5A || ext_active !== 1'b0) begin
            fails++;
            $display("FAIL revert_int_frame got %0d frames, first %h, ext_active %b want 1 frame 5a, 0",
                     rx.size(), rx.size() ? rx[0] : 8'h00, ext_active);
        end
    endtask

    task automatic test_mid_frame();
        int last_low = -1;
        rx.delete();
        make_wave(8'hE7);
        for (int i = 0; i < wave.size(); i++) begin
            set_pins(0, wave[i]);
            if (i == 40) ext_csn = 1'b0;
            if (i == 50) ext_csn = 1'b1;
            tick();
            if (i == 46 || i == 47) begin
                checks++;
                if (mcu_csn !== (i == 47)) begin
                    fails++;
                    $display("FAIL midframe_force idx %0d got csn %b want %b", i, mcu_csn, i == 47);
                end
            end
            if (wave[i][1] == 1'b0) last_low = i;
            if (i == last_low && ext_active !== 1'b0) begin
                fails++;
                $display("FAIL midframe_early idx %0d got ext_active 1 while int_csn low want 0", i);
            end
        end
        checks++;
        for (int n = 0; n < 12 && !ext_active; n++) tick();
        checks++;
        if (ext_active !== 1'b1 || rx.size() != 0) begin
            fails++;
            $display("FAIL midframe_ext got ext_active %b frames %0d want 1, 0", ext_active, rx.size());
        end
    endtask

    task automatic test_async_reset();
        int hi = 0;
        make_wave(8'h99);
        for (int i = 0; i <= 50; i++) begin
            set_pins(1, wave[i]);
            tick();
        end
        checks++;
        if (mcu_csn !== 1'b0) begin
            fails++;
            $display("FAIL async_pre got csn %b want 0", mcu_csn);
        end
        #5 por = 1'b1;
        #1;
        checks++;
        if ({mcu_csn, ext_active, mcu_sclk, mcu_mosi} !== 4'b1000) begin
            fails++;
            $display("FAIL async_por got %b want 1000", {mcu_csn, ext_active, mcu_sclk, mcu_mosi});
        end
        set_pins(1, 3'b010);
        ticks(2);
        por = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            hi |= int'(ext_active);
        end
        checks++;
        if (hi != 0) begin
            fails++;
            $display("FAIL async_requal ext_active seen %0d want 0", hi);
        end
        ext_csn = 1'b0;
        ticks(FILTER);
        ext_csn = 1'b1;
        for (int n = 0; n < 12 && !ext_active; n++) tick();
        checks++;
        if (ext_active !== 1'b1) begin
            fails++;
            $display("FAIL async_filter_exact got ext_active %b want 1 after %0d low samples", ext_active, FILTER);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int len;
        bit exp;
        ticks(110);
        checks++;
        if (ext_active !== 1'b0) begin
            fails++;
            $display("FAIL random_start got ext_active %b want 0", ext_active);
        end
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                b = 8'($urandom);
                rx.delete();
                make_wave(b);
                drive_wave(0);
                ticks(4);
                checks++;
                if (rx.size() != 1 || rx[0] !== b) begin
                    fails++;
                    $display("FAIL random_int it %0d got %0d frames, first %h want %h", it, rx.size(),
                             rx.size() ? rx[0] : 8'h00, b);
                end
            end else begin
                len = $urandom_range(1, 2 * FILTER);
                exp = len >= FILTER;
                ext_csn = 1'b0;
                ticks(len);
                ext_csn = 1'b1;
                for (int n = 0; n < 12 && !ext_active; n++) tick();
                checks++;
                if (ext_active !== exp) begin
                    fails++;
                    $display("FAIL random_qual it %0d len %0d got %b want %b", it, len, ext_active, exp);
                end
                if (exp) begin
                    b = 8'($urandom);
                    rx.delete();
                    make_wave(b);
                    drive_wave(1);
                    ticks(4);
                    checks++;
                    if (rx.size() != 1 || rx[0] !== b) begin
                        fails++;
                        $display("FAIL random_ext it %0d got %0d frames, first %h want %h", it, rx.size(),
                                 rx.size() ? rx[0] : 8'h00, b);
                    end
                    ticks(105);
                    checks++;
                    if (ext_active !== 1'b0) begin
                        fails++;
                        $display("FAIL random_revert it %0d got ext_active %b want 0", it, ext_active);
                    end
                    ticks(3);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_frame();
        test_glitch();
        test_handover();
        test_revert_boundary();
        test_revert();
        test_mid_frame();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/mcu_spi_select.md
# mcu_spi_select

Selects which MCU drives the core's SPI control link: the on-board BL616 (internal) or an external M0S Dock. Both sources' SPI inputs are synchronised into the `clk32` domain. A glitch-filtered activity detector on the external chip select hands the link over only at frame boundaries. The block sits between the board pins and the core's `mcu_*` port, and replaces the latch-on-first-low selector in the toplevel.

## Interface
Parameters:
- `FILTER`, 4: consecutive synchronised-low `ext_csn` samples (1..15) needed to qualify the external MCU.
- `REVERT_CYCLES`, 0: idle `ext_csn`-high cycles after which the link reverts to internal. 0 means latch forever. Range 0..2^24-1.

Ports:
- `clk32`  in  1  system clock, 32 MHz.
- `por`  in  1  asynchronous, active-high reset.
- `int_sclk`, `int_csn`, `int_mosi`  in  1 each  on-board BL616 SPI pins.
- `ext_sclk`, `ext_csn`, `ext_mosi`  in  1 each  M0S SPI pins. `ext_csn` has a pull-up in the constraints.
- `core_miso`  in  1  MISO from the core.
- `core_intn`  in  1  interrupt from the core.
- `int_miso`, `ext_miso`  out  1 each  copies of `core_miso`, combinational to both MCUs.
- `int_irqn`, `ext_irqn`  out  1 each  copies of `core_intn`, combinational.
- `mcu_sclk`, `mcu_csn`, `mcu_mosi`  out  1 each  selected, registered SPI to the core.
- `ext_active`  out  1  high while state is EXT.

## Operation
- Synchroniser: each of the six SPI inputs passes a 2-FF synchroniser (`s_*`). The reset value of each chain is `sclk`=0, `csn`=1, `mosi`=0.
- Output register: `mcu_*` are registered each cycle from the selected source's `s_*` signals.
  - While the state is not INT or EXT, outputs are forced idle: `csn`=1, `sclk`=0, `mosi`=0.
- Filter counter (4 bit):
  - Active in INT only.
  - Increments while `s_ext_csn`=0, saturating at `FILTER`; clears on `s_ext_csn`=1.
  - `qual` = (count == `FILTER`).
- Idle counter (24 bit):
  - Active in EXT only.
  - Increments while `s_ext_csn`=1; clears on `s_ext_csn`=0.
  - Saturates; never wraps.
- State machine, reset state INT:
  - INT: source is internal. On `qual`, go to WAIT_EXT.
  - WAIT_EXT: outputs idle. Go to EXT when `s_int_csn`=1 and `s_ext_csn`=1.
    - An internal frame in progress is therefore truncated.
    - The external frame that caused qualification is discarded by design; the MCU retries.
  - EXT: source is external. If `REVERT_CYCLES`≠0 and the idle count reaches `REVERT_CYCLES`, go to WAIT_INT.
  - WAIT_INT: outputs idle. Go to INT when `s_int_csn`=1 and `s_ext_csn`=1. The filter counter is cleared on entry to INT.
- Simultaneous events:
  - In INT, `qual` wins over any internal traffic.
  - In EXT, `s_ext_csn` falling on the same cycle the idle count would reach the limit clears the count; no revert.
- `por` asserted in any state: immediate return to INT; all counters cleared; outputs at reset values.

## Timing
- Reset values: `mcu_csn`=1, `mcu_sclk`=0, `mcu_mosi`=0, `ext_active`=0.
- `int_miso`/`ext_miso` follow `core_miso`; `int_irqn`/`ext_irqn` follow `core_intn`. All four are combinational, with no reset dependence.
- Latency from pin to `mcu_*` is 3 `clk32` edges (2 sync + 1 output register). The same latency applies to all three signals, so their relative order is preserved.
- SPI SCLK must be ≤ `clk32`/4 (≤ 8 MHz) for the core to sample correctly.
- Switch-over, with `FILTER`=4:
  - `ext_csn` pin low at edge 0 gives `s_ext_csn` low at edge 2.
  - `qual` asserts at edge 5.
  - State is WAIT_EXT from edge 6.
  - EXT is entered 1 edge after both `s_*csn` are high.
  - `ext_active` rises on the same edge as entry to EXT.
- External `csn` glitch shorter than `FILTER` samples: no state change.

## Test plan
- Reset and idle: `por` pulse, internal frame 0xA5 on `int_*` at 2 MHz → `mcu_*` reproduces the frame delayed 3 cycles; `ext_active`=0.
- Glitch rejection: `ext_csn` low for 3 `clk32` cycles with `FILTER`=4 → state stays INT; an internal frame passes unchanged.
- Handover: `ext_csn` low for 40 cycles while `int_csn` is high → WAIT_EXT, then EXT once `ext_csn` returns high; `ext_active`=1; the next external frame 0x3C appears on `mcu_*`; the first frame is absent.
- Handover mid internal frame: `qual` while `int_csn`=0 → `mcu_csn` forced 1 within 1 cycle of entering WAIT_EXT; EXT is entered only after `int_csn` rises.
- Revert with `REVERT_CYCLES`=100:
  - `ext_csn` high for 100 synchronised cycles → WAIT_INT, then INT; `ext_active`=0.
  - `ext_csn` low at cycle 99 → no revert.
- Async reset mid-frame: `por` in EXT while an external frame is active → same cycle: `mcu_csn`=1, `ext_active`=0; after release, a fresh qualification is required.
